// File: rtl/br_prediction_btb.sv
// br_prediction_btb
// Direct-mapped branch target buffer with per-entry saturating counters.
// The fetch side looks up the current PC combinationally. The resolve side
// trains the table on the rising clock edge.
//
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_br_update_*            resolved-branch training port from the BRU
//   i_current_pc             fetch PC to predict
//   o_prd_taken              prediction hit and counter says taken
//   o_prd_target             predicted next PC (table target, or PC+4)
//   o_perf_branches          accepted updates (wraps at 2^32)
//   o_perf_mispred           accepted updates whose direction was mispredicted
//
// Update port handshake: the port is valid-only, with no ready. A training
// beat is consumed on every rising edge where
// i_br_update_en && i_br_update_valid. The BRU can never be stalled.
//
// Parameters:
//   ENTRIES  number of entries, power of two, >= 2
//   CTR_W    saturating counter width, >= 1
//   EN_PRED  0 holds o_prd_taken low while the table keeps training
module br_prediction_btb #(
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter bit EN_PRED = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_br_update_en,
    input  logic        i_br_update_valid,
    input  logic        i_br_update_taken,
    input  logic        i_br_update_already_prd,
    input  logic [31:0] i_br_update_pc,
    input  logic [31:0] i_br_update_target,
    input  logic [31:0] i_current_pc,
    output logic [31:0] o_prd_target,
    output logic        o_prd_taken,
    output logic [31:0] o_perf_branches,
    output logic [31:0] o_perf_mispred
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    // Weakly taken is the MSB alone; weakly not-taken is the value just below it.
    localparam int unsigned WT_INT = 1 << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(WT_INT);
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(WT_INT - 1);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [CTR_W-1:0] ctr_q    [ENTRIES];

    // ---------------- lookup ----------------
    logic [IDX_W-1:0] cur_idx;
    logic [TAG_W-1:0] cur_tag;
    logic             cur_hit;

    assign cur_idx = i_current_pc[IDX_W+1:2];
    assign cur_tag = i_current_pc[31:IDX_W+2];
    assign cur_hit = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);

    // No bypass from the update port: a same-cycle update to this index
    // becomes visible only after the edge.
    assign o_prd_taken  = EN_PRED && cur_hit && ctr_q[cur_idx][CTR_W-1];
    assign o_prd_target = o_prd_taken ? target_q[cur_idx] : (i_current_pc + 32'd4);

    // ---------------- update ----------------
    logic             upd;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             upd_write_tgt;
    logic [CTR_W-1:0] upd_ctr;

    assign upd     = i_br_update_en && i_br_update_valid;
    assign upd_idx = i_br_update_pc[IDX_W+1:2];
    assign upd_tag = i_br_update_pc[31:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Next counter value for the addressed entry. A not-taken miss leaves it
    // alone. A taken miss allocates the entry at weakly-taken.
    always_comb begin
        upd_ctr = ctr_q[upd_idx];
        if (upd_hit) begin
            if (i_br_update_taken) begin
                if (ctr_q[upd_idx] != CTR_MAX) upd_ctr = ctr_q[upd_idx] + CTR_ONE;
            end else begin
                if (ctr_q[upd_idx] != '0) upd_ctr = ctr_q[upd_idx] - CTR_ONE;
            end
        end else if (i_br_update_taken) begin
            upd_ctr = CTR_WT;
        end
    end

    // The target is written on any taken update. On a hit this refreshes the
    // target. On a miss it is part of the allocation.
    assign upd_write_tgt = upd && i_br_update_taken;

    // Valid bits and counters carry reset. Reset wins over a concurrent update.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (upd) begin
            ctr_q[upd_idx] <= upd_ctr;
            if (!upd_hit && i_br_update_taken) valid_q[upd_idx] <= 1'b1;
        end
    end

    // Tag and target are don't-care until the valid bit is set, so they have
    // no reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst && upd_write_tgt) begin
            target_q[upd_idx] <= i_br_update_target;
            if (!upd_hit) tag_q[upd_idx] <= upd_tag;
        end
    end

    // ---------------- performance counters ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_perf_branches <= '0;
            o_perf_mispred  <= '0;
        end else if (upd) begin
            o_perf_branches <= o_perf_branches + 32'd1;
            if (i_br_update_already_prd != i_br_update_taken)
                o_perf_mispred <= o_perf_mispred + 32'd1;
        end
    end

endmodule

// File: tb/tb_br_prediction_btb.sv
// tb_br_prediction_btb
// Exercises br_prediction_btb with directed scenarios followed by random
// training and lookups. Results are checked against a table model built from
// plain integer arithmetic. A second instance with EN_PRED=0 shares every
// input and must never predict taken.
module tb_br_prediction_btb;

    localparam int ENTRIES = 64;
    localparam int CTR_W   = 2;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int CTR_MAX_I = (1 << CTR_W) - 1;
    localparam int WT_I      = 1 << (CTR_W - 1);
    localparam int WNT_I     = WT_I - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_rst = 1'b1;
    logic        i_br_update_en = 1'b0;
    logic        i_br_update_valid = 1'b0;
    logic        i_br_update_taken = 1'b0;
    logic        i_br_update_already_prd = 1'b0;
    logic [31:0] i_br_update_pc = '0;
    logic [31:0] i_br_update_target = '0;
    logic [31:0] i_current_pc = '0;

    logic [31:0] o_prd_target, o_perf_branches, o_perf_mispred;
    logic        o_prd_taken;
    logic [31:0] np_prd_target, np_perf_branches, np_perf_mispred;
    logic        np_prd_taken;

    br_prediction_btb #(.ENTRIES(ENTRIES), .CTR_W(CTR_W), .EN_PRED(1'b1)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_br_update_en(i_br_update_en), .i_br_update_valid(i_br_update_valid),
        .i_br_update_taken(i_br_update_taken),
        .i_br_update_already_prd(i_br_update_already_prd),
        .i_br_update_pc(i_br_update_pc), .i_br_update_target(i_br_update_target),
        .i_current_pc(i_current_pc),
        .o_prd_target(o_prd_target), .o_prd_taken(o_prd_taken),
        .o_perf_branches(o_perf_branches), .o_perf_mispred(o_perf_mispred)
    );

    br_prediction_btb #(.ENTRIES(ENTRIES), .CTR_W(CTR_W), .EN_PRED(1'b0)) dut_np (
        .i_clk(clk), .i_rst(i_rst),
        .i_br_update_en(i_br_update_en), .i_br_update_valid(i_br_update_valid),
        .i_br_update_taken(i_br_update_taken),
        .i_br_update_already_prd(i_br_update_already_prd),
        .i_br_update_pc(i_br_update_pc), .i_br_update_target(i_br_update_target),
        .i_current_pc(i_current_pc),
        .o_prd_target(np_prd_target), .o_prd_taken(np_prd_taken),
        .o_perf_branches(np_perf_branches), .o_perf_mispred(np_perf_mispred)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit          v;
        int unsigned tag;
        logic [31:0] tgt;
        int          ctr;
    } ent_t;

    ent_t        m_tab [ENTRIES];
    int unsigned m_br;
    int unsigned m_mp;

    function automatic int unsigned m_idx(input logic [31:0] pc);
        return (pc >> 2) % ENTRIES;
    endfunction

    function automatic int unsigned m_tag(input logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_tab[i].v   = 1'b0;
            m_tab[i].ctr = WNT_I;
        end
        m_br = 0;
        m_mp = 0;
    endfunction

    function automatic void model_apply(input bit rst, en, vld, tkn, prd,
                                        input logic [31:0] upc, utgt);
        int unsigned ix;
        bit          hit;
        if (rst) begin
            model_reset();
            return;
        end
        if (!(en && vld)) return;
        m_br = m_br + 1;
        if (prd != tkn) m_mp = m_mp + 1;
        ix  = m_idx(upc);
        hit = m_tab[ix].v && (m_tab[ix].tag == m_tag(upc));
        if (hit) begin
            if (tkn) begin
                m_tab[ix].ctr = (m_tab[ix].ctr + 1 > CTR_MAX_I) ? CTR_MAX_I : m_tab[ix].ctr + 1;
                m_tab[ix].tgt = utgt;
            end else begin
                m_tab[ix].ctr = (m_tab[ix].ctr - 1 < 0) ? 0 : m_tab[ix].ctr - 1;
            end
        end else if (tkn) begin
            m_tab[ix].v   = 1'b1;
            m_tab[ix].tag = m_tag(upc);
            m_tab[ix].tgt = utgt;
            m_tab[ix].ctr = WT_I;
        end
    endfunction

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected lookup result for the current PC against the model as it stands.
    task automatic check_lookup();
        int unsigned ix;
        bit          tk;
        logic [32:0] e;
        ix = m_idx(i_current_pc);
        tk = m_tab[ix].v && (m_tab[ix].tag == m_tag(i_current_pc)) && (m_tab[ix].ctr >= WT_I);
        exp_q.push_back({tk, tk ? m_tab[ix].tgt : i_current_pc + 32'd4});
        e = exp_q.pop_front();
        check("prd_taken", {63'd0, o_prd_taken}, {63'd0, e[32]});
        check("prd_target", {32'd0, o_prd_target}, {32'd0, e[31:0]});
        check("np_prd_taken", {63'd0, np_prd_taken}, 64'd0);
        check("np_prd_target", {32'd0, np_prd_target}, {32'd0, i_current_pc + 32'd4});
    endtask

    task automatic check_perf();
        check("perf_branches", {32'd0, o_perf_branches}, {32'd0, m_br});
        check("perf_mispred", {32'd0, o_perf_mispred}, {32'd0, m_mp});
        check("np_perf_branches", {32'd0, np_perf_branches}, {32'd0, m_br});
        check("np_perf_mispred", {32'd0, np_perf_mispred}, {32'd0, m_mp});
    endtask

    // ---------------- driver ----------------
    // One clock cycle: drive inputs, check the pre-edge lookup, and take the
    // edge. Then advance the model and check the perf counters.
    task automatic step(input bit rst, en, vld, tkn, prd,
                        input logic [31:0] upc, utgt, cpc);
        @(negedge clk);
        i_rst                   = rst;
        i_br_update_en          = en;
        i_br_update_valid       = vld;
        i_br_update_taken       = tkn;
        i_br_update_already_prd = prd;
        i_br_update_pc          = upc;
        i_br_update_target      = utgt;
        i_current_pc            = cpc;
        #1;
        check_lookup();
        @(posedge clk);
        model_apply(rst, en, vld, tkn, prd, upc, utgt);
        #1;
        check_perf();
    endtask

    task automatic idle(input logic [31:0] cpc);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, cpc);
    endtask

    task automatic train(input bit tkn, prd, input logic [31:0] upc, utgt, cpc);
        step(1'b0, 1'b1, 1'b1, tkn, prd, upc, utgt, cpc);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        // Reset.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h100);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h100);
        idle(32'h100);
        check("t1_taken", {63'd0, o_prd_taken}, 64'd0);
        check("t1_target", {32'd0, o_prd_target}, 64'h104);
        check("t1_branches", {32'd0, o_perf_branches}, 64'd0);

        // Allocation on a taken miss. The lookup in the update cycle still misses.
        train(1'b1, 1'b0, 32'h100, 32'h200, 32'h100);
        check("t2_taken", {63'd0, o_prd_taken}, 64'd1);
        check("t2_target", {32'd0, o_prd_target}, 64'h200);
        check("t2_branches", {32'd0, o_perf_branches}, 64'd1);
        check("t2_mispred", {32'd0, o_perf_mispred}, 64'd1);

        // Counter walk: 10 -> 01 -> 00 -> 01 -> 10 -> 11 -> 10.
        train(1'b0, 1'b1, 32'h100, 32'h0, 32'h100);
        check("t3_nt1_taken", {63'd0, o_prd_taken}, 64'd0);
        train(1'b0, 1'b0, 32'h100, 32'h0, 32'h100);
        train(1'b1, 1'b0, 32'h100, 32'h200, 32'h100);
        train(1'b1, 1'b0, 32'h100, 32'h200, 32'h100);
        train(1'b1, 1'b1, 32'h100, 32'h200, 32'h100);
        train(1'b0, 1'b1, 32'h100, 32'h0, 32'h100);
        check("t3_final_taken", {63'd0, o_prd_taken}, 64'd1);
        check("t3_final_target", {32'd0, o_prd_target}, 64'h200);

        // Aliasing at index 0.
        idle(32'h200);
        check("t4_alias_miss", {32'd0, o_prd_target}, 64'h204);
        train(1'b1, 1'b0, 32'h200, 32'h300, 32'h200);
        idle(32'h100);
        check("t4_evicted", {32'd0, o_prd_target}, 64'h104);

        // Ignored update (valid low). Then an update racing a lookup on the same index.
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h999, 32'h200);
        check("t5_ignored", {32'd0, o_prd_target}, 64'h300);
        train(1'b0, 1'b1, 32'h200, 32'h0, 32'h200);
        train(1'b0, 1'b1, 32'h200, 32'h0, 32'h200);

        // Reset concurrent with a taken update.
        train(1'b1, 1'b0, 32'h100, 32'h200, 32'h100);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h200, 32'h100);
        idle(32'h100);
        check("t6_miss", {63'd0, o_prd_taken}, 64'd0);
        check("t6_branches", {32'd0, o_perf_branches}, 64'd0);

        // Random phase. PCs come from a small pool so hits, aliases and evictions are frequent.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] upc, cpc;
            upc = {26'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            cpc = {26'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            upc = {upc[29:6], upc[5:0]} << 2 | (upc & 32'h3);
            cpc = {cpc[29:6], cpc[5:0]} << 2 | (cpc & 32'h3);
            if (n % 4 == 0) cpc = upc;
            step($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)) | 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 upc, $urandom, cpc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/br_prediction_btb.md
Name: br_prediction_btb

Overview:
Parametrised branch target buffer with per-entry saturating counters, the successor to the fixed not-taken predictor inside next_pc_unit.
- Fetch side: combinational lookup on i_current_pc returns a taken prediction and a target in the same cycle.
- Resolve side: the BRU update port trains the table on the rising clock edge.
- Two 32-bit performance counters track resolved branches and mispredictions.

Parameters:
ENTRIES, 64, number of BTB entries; power of two, at least 2; IDX_W = log2(ENTRIES).
CTR_W, 2, saturating counter width, at least 1.
EN_PRED, 1, 0 forces o_prd_taken low (legacy mode); the table still trains.

Ports:
i_clk  in  1  clock.
i_rst  in  1  synchronous active-high reset.
i_br_update_en  in  1  BRU result available this cycle.
i_br_update_valid  in  1  the resolved instruction is a real branch/jump (not squashed).
i_br_update_taken  in  1  actual outcome is taken.
i_br_update_already_prd  in  1  the resolved branch was predicted taken at fetch.
i_br_update_pc  in  32  PC of the resolved branch.
i_br_update_target  in  32  actual target.
i_current_pc  in  32  fetch PC to predict.
o_prd_target  out  32  predicted next PC.
o_prd_taken  out  1  prediction hit and taken.
o_perf_branches  out  32  count of accepted updates.
o_perf_mispred  out  32  count of mispredicted updates.

Behaviour:
- Address split:
  - idx = pc[IDX_W+1:2].
  - tag = pc[31:IDX_W+2].
  - pc[1:0] is ignored.
- Entry contents: valid, tag, target[31:0], ctr[CTR_W-1:0]. All held in flops.
- Reset: one cycle of i_rst while clocked sets:
  - every valid to 0;
  - every ctr to WNT = 2^(CTR_W-1)-1;
  - both perf counters to 0.
  - Tag and target are don't-care after reset.
- Reset asserted mid-training wins over any concurrent update.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx] == tag(i_current_pc).
  - o_prd_taken = EN_PRED && hit && ctr[idx][CTR_W-1].
  - o_prd_target = target[idx] when o_prd_taken, else i_current_pc + 32'd4 (wraps modulo 2^32).
  - Outputs are valid during reset, reflecting the table as it stands that cycle.
- Update accept: upd = i_br_update_en && i_br_update_valid, sampled on the rising edge. If upd = 0 the table and perf counters hold.
- Update on hit (entry valid and tag matches):
  - Taken: ctr = min(ctr+1, 2^CTR_W-1) and target = i_br_update_target.
  - Not taken: ctr = max(ctr-1, 0); target unchanged.
- Update on miss:
  - Taken: allocate (overwrite) the entry at idx with valid=1, new tag, target = i_br_update_target, ctr = WT = 2^(CTR_W-1).
  - Not taken: no change.
- Entries are never invalidated except by reset. Aliasing PCs replace each other (direct mapped).
- Simultaneous lookup and update to the same index: the lookup sees the pre-update contents; there is no bypass. The new state is visible the cycle after the edge.
- Perf counters, on upd only:
  - o_perf_branches += 1.
  - o_perf_mispred += 1 when i_br_update_already_prd != i_br_update_taken.
  - Both counters wrap from 0xFFFFFFFF to 0.
- A wrong target with a correct direction is not counted by o_perf_mispred; the BRU handles that case.

Test Plan:
1. Reset, then i_current_pc=0x100 -> o_prd_taken=0, o_prd_target=0x104, both perf counters 0.
2. Update pc=0x100, taken=1, target=0x200, already_prd=0 -> next cycle with current_pc=0x100: o_prd_taken=1, o_prd_target=0x200, o_perf_branches=1, o_perf_mispred=1.
3. From step 2 state, two not-taken updates at pc=0x100:
   - After the first: ctr 10->01, o_prd_taken=0, target still 0x200 in the entry.
   - After the second: ctr=00.
   - Three taken updates then give ctr=11; one not-taken gives ctr=10 and o_prd_taken stays 1.
4. Alias (ENTRIES=64): with 0x100 allocated, lookup 0x200 (same idx 0, tag 2) -> miss, target 0x204. Taken update at 0x200 with target 0x300 evicts it, and 0x100 then misses.
5. Ignored updates:
   - en=1, valid=0 -> table and perf counters unchanged.
   - Update and lookup of the same idx in one cycle -> the output reflects the old entry.
6. Mid-run reset after step 2:
   - Pulse i_rst one cycle concurrent with a taken update -> 0x100 misses and perf counters read 0.
   - EN_PRED=0 build -> o_prd_taken stays 0 throughout while the counters still increment.
